// File: rtl/dfd_arb_pkg.sv
// Shared helpers for the arbitration stage and its priority encoders.
package dfd_arb_pkg;

   // Source-index width: enough bits to name every requester, never zero.
   function automatic int src_width(input int width);
      return (width > 1) ? $clog2(width) : 1;
   endfunction

endpackage

// File: rtl/generic_ffs.sv
// Find-first-set priority encoder: one-hot grant, encoded index and the selected payload.
module generic_ffs #(
   parameter int WIDTH      = 4,
   parameter int SIZE       = 2,
   parameter int DIR_L2H    = 1,
   parameter int DATA_WIDTH = 8
) (
   input  logic [WIDTH-1:0]                 req_in,
   input  logic [WIDTH-1:0][DATA_WIDTH-1:0] data_in,
   output logic                             req_sum,
   output logic [WIDTH-1:0]                 req_out,
   output logic [SIZE-1:0]                  enc_req_out,
   output logic [DATA_WIDTH-1:0]            data_out
);

   // Low-to-high keeps the first hit; high-to-low lets later (higher) hits overwrite.
   always_comb begin
      req_sum     = 1'b0;
      req_out     = '0;
      enc_req_out = '0;
      data_out    = '0;
      for (int j = 0; j < WIDTH; j++) begin
         if (req_in[j] && ((DIR_L2H == 0) || !req_sum)) begin
            req_out     = '0;
            req_out[j]  = 1'b1;
            enc_req_out = SIZE'(j);
            data_out    = data_in[j];
            req_sum     = 1'b1;
         end
      end
   end

endmodule

// File: rtl/rr_arb_stage.sv
// Registered round-robin arbiter: N valid/ready requesters funnel into one registered output beat.
module rr_arb_stage
   import dfd_arb_pkg::*;
#(
   parameter int WIDTH      = 4,
   parameter int SIZE       = src_width(WIDTH),
   parameter int DATA_WIDTH = 8
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic [WIDTH-1:0]                 in_valid,
   input  logic [WIDTH-1:0][DATA_WIDTH-1:0] in_data,
   output logic [WIDTH-1:0]                 in_ready,
   output logic                             out_valid,
   input  logic                             out_ready,
   output logic [DATA_WIDTH-1:0]            out_data,
   output logic [SIZE-1:0]                  out_src
);

   typedef logic [SIZE-1:0] arb_src_t;
   typedef struct packed {
      logic [DATA_WIDTH-1:0] data;
      arb_src_t              src;
   } arb_beat_t;

   arb_src_t              ptr;
   arb_beat_t             beat_q;
   arb_beat_t             win_beat;
   logic                  load_en;
   logic                  grant;
   logic                  m_sum;
   logic                  u_sum;
   logic [WIDTH-1:0]      req_m;
   logic [WIDTH-1:0]      m_oh;
   logic [WIDTH-1:0]      u_oh;
   logic [WIDTH-1:0]      win_oh;
   arb_src_t              m_enc;
   arb_src_t              u_enc;
   logic [DATA_WIDTH-1:0] m_data;
   logic [DATA_WIDTH-1:0] u_data;

   // Explicit compare instead of modulo so non-power-of-two WIDTH wraps correctly.
   function automatic arb_src_t next_ptr(input arb_src_t w);
      if (w == arb_src_t'(WIDTH - 1)) return '0;
      return w + arb_src_t'(1);
   endfunction

   always_comb begin
      req_m = '0;
      for (int i = 0; i < WIDTH; i++) begin
         req_m[i] = in_valid[i] && (i >= int'(ptr));
      end
   end

   generic_ffs #(.WIDTH(WIDTH), .SIZE(SIZE), .DIR_L2H(1), .DATA_WIDTH(DATA_WIDTH)) u_ffs_masked (
      .req_in      (req_m),
      .data_in     (in_data),
      .req_sum     (m_sum),
      .req_out     (m_oh),
      .enc_req_out (m_enc),
      .data_out    (m_data)
   );

   generic_ffs #(.WIDTH(WIDTH), .SIZE(SIZE), .DIR_L2H(1), .DATA_WIDTH(DATA_WIDTH)) u_ffs_all (
      .req_in      (in_valid),
      .data_in     (in_data),
      .req_sum     (u_sum),
      .req_out     (u_oh),
      .enc_req_out (u_enc),
      .data_out    (u_data)
   );

   // Anything at or above the pointer wins first; otherwise wrap to the lowest requester.
   always_comb begin
      win_oh        = m_sum ? m_oh : u_oh;
      win_beat.src  = m_sum ? m_enc : u_enc;
      win_beat.data = m_sum ? m_data : u_data;
   end

   assign load_en   = !out_valid || out_ready;
   assign grant     = load_en && u_sum && !reset;
   assign in_ready  = win_oh & {WIDTH{load_en && !reset}};
   assign out_data  = beat_q.data;
   assign out_src   = beat_q.src;

   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid <= 1'b0;
         beat_q    <= '0;
         ptr       <= '0;
      end else if (grant) begin
         out_valid <= 1'b1;
         beat_q    <= win_beat;
         ptr       <= next_ptr(win_beat.src);
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule
